// File: rtl/start_screen_ctrl.sv
// Game-flow sequencer: TITLE -> COUNTDOWN -> PLAY -> GAMEOVER, driving banner blink,
// countdown digit, game_run and a one-cycle game_clear on every countdown entry.
module start_screen_ctrl #(
    parameter logic [7:0]  START_KEY  = 8'h28,
    parameter int unsigned BLINK_FRM  = 30,
    parameter int unsigned SEC_FRM    = 60,
    parameter int unsigned COUNT_INIT = 3,
    parameter int unsigned HOLD_FRM   = 120
) (
    input  logic       Clk,
    input  logic       Reset,
    input  logic       frame_clk,
    input  logic [7:0] keycode,
    input  logic       player_dead,
    output logic [1:0] game_state,
    output logic       start_visible,
    output logic [3:0] countdown,
    output logic       game_run,
    output logic       game_clear
);
    localparam int unsigned FCNT_W = 8;
    localparam int unsigned CD_W   = 4;

    localparam logic [FCNT_W-1:0] BLINK_LAST = FCNT_W'(BLINK_FRM - 1);
    localparam logic [FCNT_W-1:0] SEC_LAST   = FCNT_W'(SEC_FRM - 1);
    localparam logic [FCNT_W-1:0] HOLD_LAST  = FCNT_W'(HOLD_FRM - 1);
    localparam logic [CD_W-1:0]   CD_INIT    = CD_W'(COUNT_INIT);

    typedef enum logic [1:0] {
        ST_TITLE = 2'b00,
        ST_COUNT = 2'b01,
        ST_PLAY  = 2'b10,
        ST_OVER  = 2'b11
    } state_e;

    state_e            state_q, state_d;
    logic [FCNT_W-1:0] fcnt_q, fcnt_d;
    logic              frame_clk_q, frame_clk_d;
    logic              key_q, key_d;
    logic              hold_done_q, hold_done_d;
    logic              start_visible_q, start_visible_d;
    logic [CD_W-1:0]   countdown_q, countdown_d;
    logic              game_run_q, game_run_d;
    logic              game_clear_q, game_clear_d;

    logic              tick;
    logic              press;
    logic              wrap;
    logic [FCNT_W-1:0] lim_last;

    always_comb begin
        frame_clk_d = frame_clk;
        key_d       = (keycode == START_KEY);
        tick        = frame_clk & ~frame_clk_q;
        press       = key_d & ~key_q;

        unique case (state_q)
            ST_TITLE: lim_last = BLINK_LAST;
            ST_COUNT: lim_last = SEC_LAST;
            ST_OVER:  lim_last = HOLD_LAST;
            default:  lim_last = '1;
        endcase
        wrap = tick && (fcnt_q == lim_last);
    end

    // Next-state and registered-output computation
    always_comb begin
        state_d         = state_q;
        fcnt_d          = fcnt_q;
        hold_done_d     = hold_done_q;
        start_visible_d = start_visible_q;
        countdown_d     = countdown_q;
        game_run_d      = game_run_q;
        game_clear_d    = 1'b0;

        if (tick) begin
            fcnt_d = wrap ? '0 : fcnt_q + FCNT_W'(1);
        end

        unique case (state_q)
            ST_TITLE: begin
                if (press) begin
                    state_d         = ST_COUNT;
                    countdown_d     = CD_INIT;
                    start_visible_d = 1'b1;
                    game_clear_d    = 1'b1;
                end else if (wrap) begin
                    start_visible_d = ~start_visible_q;
                end
            end
            ST_COUNT: begin
                if (wrap) begin
                    if (countdown_q > CD_W'(1)) begin
                        countdown_d = countdown_q - CD_W'(1);
                    end else begin
                        state_d         = ST_PLAY;
                        countdown_d     = '0;
                        start_visible_d = 1'b0;
                        game_run_d      = 1'b1;
                    end
                end
            end
            ST_PLAY: begin
                if (player_dead) begin
                    state_d         = ST_OVER;
                    game_run_d      = 1'b0;
                    start_visible_d = 1'b1;
                end
            end
            ST_OVER: begin
                start_visible_d = 1'b1;
                // Presses before the hold expires are dropped, never queued
                if (press && hold_done_q) begin
                    state_d      = ST_COUNT;
                    countdown_d  = CD_INIT;
                    game_clear_d = 1'b1;
                end else if (wrap) begin
                    hold_done_d = 1'b1;
                end
            end
            default: ;
        endcase

        if (state_d != state_q) begin
            fcnt_d      = '0;
            hold_done_d = 1'b0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q         <= ST_TITLE;
            fcnt_q          <= '0;
            frame_clk_q     <= 1'b0;
            key_q           <= 1'b0;
            hold_done_q     <= 1'b0;
            start_visible_q <= 1'b1;
            countdown_q     <= '0;
            game_run_q      <= 1'b0;
            game_clear_q    <= 1'b0;
        end else begin
            state_q         <= state_d;
            fcnt_q          <= fcnt_d;
            frame_clk_q     <= frame_clk_d;
            key_q           <= key_d;
            hold_done_q     <= hold_done_d;
            start_visible_q <= start_visible_d;
            countdown_q     <= countdown_d;
            game_run_q      <= game_run_d;
            game_clear_q    <= game_clear_d;
        end
    end

    assign game_state    = state_q;
    assign start_visible = start_visible_q;
    assign countdown     = countdown_q;
    assign game_run      = game_run_q;
    assign game_clear    = game_clear_q;

endmodule

// File: tb/tb_start_screen_ctrl.sv
// Bench for start_screen_ctrl: tick-count reference model compared every cycle,
// plus directed literal checks of the game-flow scenarios.
module tb_start_screen_ctrl;
    localparam int unsigned BLINK = 30;
    localparam int unsigned SEC   = 60;
    localparam int unsigned CI    = 3;
    localparam int unsigned HOLD  = 120;
    localparam logic [7:0]  KEY   = 8'h28;

    logic       clk;
    logic       reset;
    logic       frame_clk;
    logic [7:0] keycode;
    logic       player_dead;
    logic [1:0] game_state;
    logic       start_visible;
    logic [3:0] countdown;
    logic       game_run;
    logic       game_clear;

    int checks = 0;
    int errors = 0;
    int clear_cnt = 0;
    bit mon_en = 0;

    start_screen_ctrl dut (
        .Clk          (clk),
        .Reset        (reset),
        .frame_clk    (frame_clk),
        .keycode      (keycode),
        .player_dead  (player_dead),
        .game_state   (game_state),
        .start_visible(start_visible),
        .countdown    (countdown),
        .game_run     (game_run),
        .game_clear   (game_clear)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: state plus ticks elapsed since entering it
    int m_state = 0;
    int m_ticks = 0;
    bit m_fprev = 0;
    bit m_kprev = 0;
    bit m_clr   = 0;

    always @(posedge clk) begin
        bit tk;
        bit pr;
        tk = frame_clk && !m_fprev;
        pr = (keycode == KEY) && !m_kprev;
        m_fprev = frame_clk;
        m_kprev = (keycode == KEY);
        m_clr = 0;
        if (reset) begin
            m_state = 0;
            m_ticks = 0;
            m_fprev = 0;
            m_kprev = 0;
        end else begin
            case (m_state)
                0: if (pr) begin m_state = 1; m_ticks = 0; m_clr = 1; end
                   else if (tk) m_ticks++;
                1: if (tk) begin
                       m_ticks++;
                       if (m_ticks == int'(SEC * CI)) begin m_state = 2; m_ticks = 0; end
                   end
                2: if (player_dead) begin m_state = 3; m_ticks = 0; end
                default: if (pr && m_ticks >= int'(HOLD)) begin m_state = 1; m_ticks = 0; m_clr = 1; end
                         else if (tk) m_ticks++;
            endcase
        end
    end

    function automatic logic [8:0] model_out();
        logic       vis;
        logic [3:0] cd;
        vis = 1'b1;
        cd  = 4'd0;
        if (m_state == 0) vis = ((m_ticks / int'(BLINK)) % 2) == 0;
        if (m_state == 2) vis = 1'b0;
        if (m_state == 1) cd = 4'(int'(CI) - m_ticks / int'(SEC));
        return {2'(m_state), vis, cd, logic'(m_state == 2), logic'(m_clr)};
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One cycle; compares the whole output vector against the model
    task automatic step();
        @(negedge clk);
        if (mon_en) begin
            chk("model", int'({game_state, start_visible, countdown, game_run, game_clear}),
                int'(model_out()));
            if (game_clear) clear_cnt++;
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) step();
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            frame_clk = 1'b1;
            step();
            frame_clk = 1'b0;
            step();
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, int'(game_state), 0);
        chk({tag, "_vis"}, int'(start_visible), 1);
        chk({tag, "_cd"}, int'(countdown), 0);
        chk({tag, "_run"}, int'(game_run), 0);
        chk({tag, "_clear"}, int'(game_clear), 0);
    endtask

    initial begin
        reset = 1'b1;
        frame_clk = 1'b0;
        keycode = 8'h00;
        player_dead = 1'b0;
        step();
        mon_en = 1;
        step();
        chk_reset_vals("reset");
        reset = 1'b0;

        // 1: banner blink in TITLE
        ticks(29);
        chk("blink_29", int'(start_visible), 1);
        ticks(1);
        chk("blink_30", int'(start_visible), 0);
        ticks(30);
        chk("blink_60", int'(start_visible), 1);
        chk("title_run", int'(game_run), 0);

        // 2: held start key -> single countdown run
        keycode = KEY;
        step();
        chk("cd_entry_state", int'(game_state), 1);
        chk("cd_entry_clear", int'(game_clear), 1);
        chk("cd_entry_val", int'(countdown), 3);
        step();
        chk("cd_clear_pulse", int'(game_clear), 0);
        ticks(59);
        chk("cd3_hold", int'(countdown), 3);
        ticks(1);
        chk("cd2", int'(countdown), 2);
        ticks(60);
        chk("cd1", int'(countdown), 1);
        ticks(59);
        chk("cd1_hold_state", int'(game_state), 1);
        ticks(1);
        chk("play_state", int'(game_state), 2);
        chk("play_run", int'(game_run), 1);
        chk("play_cd", int'(countdown), 0);
        chk("play_vis", int'(start_visible), 0);
        chk("one_clear", clear_cnt, 1);
        keycode = 8'h00;
        cycles(3);

        // 3: death -> GAMEOVER
        player_dead = 1'b1;
        step();
        player_dead = 1'b0;
        chk("over_state", int'(game_state), 3);
        chk("over_run", int'(game_run), 0);
        chk("over_vis", int'(start_visible), 1);

        // 4: early press dropped, late press accepted
        ticks(50);
        keycode = KEY;
        step();
        keycode = 8'h00;
        step();
        chk("early_press", int'(game_state), 3);
        ticks(70);
        chk("hold_state", int'(game_state), 3);
        keycode = KEY;
        step();
        chk("restart_state", int'(game_state), 1);
        chk("restart_clear", int'(game_clear), 1);
        chk("restart_cd", int'(countdown), 3);
        keycode = 8'h00;
        step();
        chk("two_clears", clear_cnt, 2);

        // 5: press and tick together in TITLE
        reset = 1'b1;
        step();
        reset = 1'b0;
        ticks(5);
        keycode = KEY;
        frame_clk = 1'b1;
        step();
        frame_clk = 1'b0;
        keycode = 8'h00;
        chk("tie_state", int'(game_state), 1);
        chk("tie_cd", int'(countdown), 3);
        step();
        ticks(59);
        chk("tie_fcnt_59", int'(countdown), 3);
        ticks(1);
        chk("tie_fcnt_60", int'(countdown), 2);

        // 6: reset from COUNTDOWN and from PLAY
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("rst_cd");
        keycode = KEY;
        step();
        keycode = 8'h00;
        ticks(180);
        chk("play_again", int'(game_state), 2);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_reset_vals("rst_play");
        cycles(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
